oserdes_mem_soft: RTL

//  Multi-lane soft serializer for DDR3 DQ/DQS lanes, built from fabric logic in a single clock domain.
//  - Accepts one parallel word per RATIO clocks through a valid/ready handshake.
//  - Shifts each word out LSB-first, one bit per lane per clock.
//  - Generates a shared tristate control with programmable preamble/postamble, so

---
 rtl/oserdes_mem_soft.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/oserdes_mem_soft.sv
// Soft multi-lane serializer for DDR3 DQ/DQS lanes with preamble/postamble tristate control.
// Optional burst word counter is enabled by defining OSERDES_MEM_SOFT_BURST_CNT_EN.
module oserdes_mem_soft #(
   parameter int   LANES       = 8,
   parameter int   RATIO       = 4,
   parameter int   PRE_CYCLES  = 1,
   parameter int   POST_CYCLES = 1,
   parameter logic DOUT_IDLE   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [LANES*RATIO-1:0] din,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [LANES-1:0]       dout,
   output logic                   tout
`ifdef OSERDES_MEM_SOFT_BURST_CNT_EN
   ,
   output logic [15:0]            burst_words
`endif
);

   // state | meaning
   // IDLE  | lanes released (tout=1); waiting for a word
   // PRE   | preamble: driving idle value before first data bit
   // DATA  | shifting the loaded word out LSB-first
   // POST  | postamble: driving idle value after last data bit

   if (LANES < 1 || LANES > 64) begin : g_bad_lanes
      $error("oserdes_mem_soft: LANES=%0d out of range 1..64", LANES);
   end
   if (RATIO < 2 || RATIO > 8) begin : g_bad_ratio
      $error("oserdes_mem_soft: RATIO=%0d out of range 2..8", RATIO);
   end
   if (PRE_CYCLES < 0 || PRE_CYCLES > 7) begin : g_bad_pre
      $error("oserdes_mem_soft: PRE_CYCLES=%0d out of range 0..7", PRE_CYCLES);
   end
   if (POST_CYCLES < 0 || POST_CYCLES > 7) begin : g_bad_post
      $error("oserdes_mem_soft: POST_CYCLES=%0d out of range 0..7", POST_CYCLES);
   end

   localparam int CW = ($clog2(RATIO) > 3) ? $clog2(RATIO) : 3;
   localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_CYCLES  > 0) ? PRE_CYCLES  - 1 : 0);
   localparam logic [CW-1:0] POST_LAST = CW'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
   localparam logic [CW-1:0] DATA_LAST = CW'(RATIO - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_POST = 2'd3
   } state_t;

   state_t                       state, state_nxt;
   logic [CW-1:0]                cnt, cnt_nxt;
   logic [LANES-1:0][RATIO-1:0]  sreg, sreg_nxt;
   logic [LANES-1:0]             dout_nxt;
   logic                         xfer;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sreg_nxt  = sreg;
      din_ready = 1'b0;
      xfer      = 1'b0;
      case (state)
         S_IDLE: begin
            if (PRE_CYCLES == 0) begin
               din_ready = 1'b1;
               if (din_valid) begin
                  xfer      = 1'b1;
                  sreg_nxt  = din;
                  state_nxt = S_DATA;
                  cnt_nxt   = '0;
               end
            end else if (din_valid) begin
               state_nxt = S_PRE;
               cnt_nxt   = '0;
            end
         end
         S_PRE: begin
            din_ready = (cnt == PRE_LAST);
            if (din_ready && din_valid) begin
               xfer      = 1'b1;
               sreg_nxt  = din;
               state_nxt = S_DATA;
               cnt_nxt   = '0;
            end else if (!din_ready) begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DATA: begin
            for (int l = 0; l < LANES; l++) begin
               sreg_nxt[l] = sreg[l] >> 1;
            end
            cnt_nxt   = cnt + CW'(1);
            din_ready = (cnt == DATA_LAST);
            if (din_ready) begin
               cnt_nxt = '0;
               if (din_valid) begin
                  xfer     = 1'b1;
                  sreg_nxt = din;
               end else if (POST_CYCLES > 0) begin
                  state_nxt = S_POST;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_POST: begin
            if (cnt == POST_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are registered from next-state values so bit0 appears the cycle after the transfer.
   always_comb begin
      dout_nxt = {LANES{DOUT_IDLE}};
      for (int l = 0; l < LANES; l++) begin
         dout_nxt[l] = (state_nxt == S_DATA) ? sreg_nxt[l][0] : DOUT_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
         sreg  <= '0;
         tout  <= 1'b1;
         dout  <= {LANES{DOUT_IDLE}};
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         sreg  <= sreg_nxt;
         tout  <= (state_nxt == S_IDLE);
         dout  <= dout_nxt;
      end
   end

`ifdef OSERDES_MEM_SOFT_BURST_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         burst_words <= '0;
      end else if (state == S_IDLE && state_nxt != S_IDLE) begin
         burst_words <= xfer ? 16'd1 : 16'd0;
      end else if (xfer && burst_words != 16'hFFFF) begin
         burst_words <= burst_words + 16'd1;
      end
   end
`endif

endmodule
